// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding and
// forwarding-mux select codes.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN,
    LU_STALL,
    DRAIN,
    HALTED
  } hz_state_t;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF = 2'b00;
  localparam fwd_sel_t FWD_S4 = 2'b01;
  localparam fwd_sel_t FWD_S5 = 2'b10;

endpackage

// File: rtl/pipe_fwd_sel.sv
// Per-operand forwarding select: the EX/MEM result wins over the MEM/WB result,
// and register 0 never forwards.
module pipe_fwd_sel
  import pipe_pkg::*;
#(
  parameter int unsigned ADDR_LEFT = 4
) (
  input  logic [ADDR_LEFT:0] src_addr,
  input  logic               rw_s4,
  input  logic               sel_mem_s4,
  input  logic [ADDR_LEFT:0] waddr_s4,
  input  logic               rw_s5,
  input  logic [ADDR_LEFT:0] waddr_s5,
  output fwd_sel_t           sel
);

  logic src_nz;
  logic hit_s4;
  logic hit_s5;

  assign src_nz = (src_addr != '0);
  // A load in EX/MEM has no data yet, so it cannot be a forwarding source.
  assign hit_s4 = !rw_s4 && !sel_mem_s4 && (waddr_s4 == src_addr) && src_nz;
  assign hit_s5 = !rw_s5 && (waddr_s5 == src_addr) && src_nz;

  always_comb begin
    sel = FWD_RF;
    if (hit_s4) begin
      sel = FWD_S4;
    end else if (hit_s5) begin
      sel = FWD_S5;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctl.sv
// Hazard and forwarding controller for the 5-stage core: operand forwarding,
// load-use stalls, data-memory freeze, halt sequencing and a stall counter.
module pipe_hazard_ctl
  import pipe_pkg::*;
#(
  parameter int unsigned REG_WORDS  = 32,
  parameter int unsigned ADDR_LEFT  = $clog2(REG_WORDS) - 1,
  parameter int unsigned LOAD_STALL = 1,
  parameter int unsigned CNT_BITS   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_LEFT:0]  r1_addr_s2,
  input  logic [ADDR_LEFT:0]  r2_addr_s2,
  input  logic                uses_r1_s2,
  input  logic                uses_r2_s2,
  input  logic                halt_s2,
  input  logic [ADDR_LEFT:0]  r1_addr_s3,
  input  logic [ADDR_LEFT:0]  r2_addr_s3,
  input  logic                rw_s3,
  input  logic                sel_mem_s3,
  input  logic [ADDR_LEFT:0]  waddr_s3,
  input  logic                rw_s4,
  input  logic                sel_mem_s4,
  input  logic [ADDR_LEFT:0]  waddr_s4,
  input  logic                rw_s5,
  input  logic [ADDR_LEFT:0]  waddr_s5,
  input  logic                halt_s5,
  input  logic                mem_busy,
  output logic [1:0]          fwd_r1_sel,
  output logic [1:0]          fwd_r2_sel,
  output logic                stall_if,
  output logic                stall_id,
  output logic                flush_s3,
  output logic                freeze,
  output logic                halted,
  output logic [CNT_BITS-1:0] stall_cnt
);

  localparam logic [1:0] LuInit = 2'(LOAD_STALL - 1);

  hz_state_t            state_q, state_d;
  logic [1:0]           ctr_q, ctr_d;
  logic [CNT_BITS-1:0]  stall_cnt_q;
  logic                 lu;
  logic                 lu_r1;
  logic                 lu_r2;

  pipe_fwd_sel #(
    .ADDR_LEFT (ADDR_LEFT)
  ) u_fwd_r1 (
    .src_addr   (r1_addr_s3),
    .rw_s4      (rw_s4),
    .sel_mem_s4 (sel_mem_s4),
    .waddr_s4   (waddr_s4),
    .rw_s5      (rw_s5),
    .waddr_s5   (waddr_s5),
    .sel        (fwd_r1_sel)
  );

  pipe_fwd_sel #(
    .ADDR_LEFT (ADDR_LEFT)
  ) u_fwd_r2 (
    .src_addr   (r2_addr_s3),
    .rw_s4      (rw_s4),
    .sel_mem_s4 (sel_mem_s4),
    .waddr_s4   (waddr_s4),
    .rw_s5      (rw_s5),
    .waddr_s5   (waddr_s5),
    .sel        (fwd_r2_sel)
  );

  assign lu_r1  = uses_r1_s2 && (r1_addr_s2 == waddr_s3);
  assign lu_r2  = uses_r2_s2 && (r2_addr_s2 == waddr_s3);
  assign lu     = sel_mem_s3 && !rw_s3 && (waddr_s3 != '0) && (lu_r1 || lu_r2);
  assign freeze = mem_busy && (state_q != HALTED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      ctr_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
    end
  end

  // While frozen, state and counter hold; lu and halt are re-evaluated later.
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    if (!freeze) begin
      unique case (state_q)
        RUN: begin
          if (lu) begin
            ctr_d = LuInit;
            if (LuInit != 2'd0) begin
              state_d = LU_STALL;
            end
          end else if (halt_s2) begin
            state_d = DRAIN;
          end
        end
        LU_STALL: begin
          ctr_d = ctr_q - 2'd1;
          if (ctr_q <= 2'd1) begin
            state_d = RUN;
          end
        end
        DRAIN: begin
          if (halt_s5) begin
            state_d = HALTED;
          end
        end
        HALTED: begin
          state_d = HALTED;
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  always_comb begin
    stall_if = 1'b0;
    stall_id = 1'b0;
    flush_s3 = 1'b0;
    halted   = 1'b0;
    unique case (state_q)
      RUN: begin
        if (lu && !freeze) begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          flush_s3 = 1'b1;
        end
      end
      LU_STALL: begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        flush_s3 = 1'b1;
      end
      DRAIN: begin
        stall_if = 1'b1;
      end
      HALTED: begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        flush_s3 = 1'b1;
        halted   = 1'b1;
      end
      default: begin
        stall_if = 1'b0;
      end
    endcase
    // A frozen ID/EX keeps its contents, so injecting a bubble would drop an instruction.
    if (freeze) begin
      flush_s3 = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if ((state_q != HALTED) && (stall_id || freeze) && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + {{(CNT_BITS - 1){1'b0}}, 1'b1};
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule
